cond_flag_unit: RTL and testbench
=================================

// Module: cond_flag_unit
// PURPOSE
//  Downstream of the instruction decoder: evaluates the 4-bit ARM condition field against the
//  architectural NZCV flag register, gates the decoder's PCS/RegW/MemW strobes into committed
//  PCSrc/RegWrite/MemWrite, and updates NZCV from the ALU under FlagW control. Holds the only
//  copy of the flags; also keeps a saturating count of squashed (condition-failed) instructions.
// PARAMETERS
//  CNT_W    16   width of the squashed-instruction counter SquashCnt
// PORTS
//  clk        in   1      core clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-low reset
//  Stall      in   1      1 = hold current instruction: no flag update, no counter update, strobes forced 0
//  Cond       in   4      instruction bits [31:28]
//  ALUFlags   in   4      {N,Z,C,V} from ALU for the current instruction
//  FlagW      in   2      from decoder; [1] = write N,Z; [0] = write C,V
//  PCS        in   1      from decoder; instruction writes PC (branch or Rd==R15 with RegW)
//  RegW       in   1      from decoder; register-file write request
//  MemW       in   1      from decoder; data-memory write request
//  PCSrc      out  1      PCS  & CondEx & ~Stall
//  RegWrite   out  1      RegW & CondEx & ~Stall
//  MemWrite   out  1      MemW & CondEx & ~Stall
//  CondEx     out  1      condition passed (combinational, from registered Flags)
//  Flags      out  4      registered {N,Z,C,V}
//  SquashCnt  out  CNT_W  count of non-stalled cycles with CondEx==0, saturating
// BEHAVIOUR
//  - Reset (reset==0, async): Flags=4'b0000, SquashCnt=0. Outputs PCSrc/RegWrite/MemWrite follow
//    combinationally and are 0 whenever Stall=1; no other output is registered.
//  - Condition evaluated on registered Flags only (never on same-cycle ALUFlags):
//    0000 EQ Z | 0001 NE !Z | 0010 CS C | 0011 CC !C | 0100 MI N | 0101 PL !N | 0110 VS V
//    0111 VC !V | 1000 HI C&!Z | 1001 LS !C|Z | 1010 GE N==V | 1011 LT N!=V
//    1100 GT !Z&(N==V) | 1101 LE Z|(N!=V) | 1110 AL 1 | 1111 treated as AL (CondEx=1).
//  - Flag write, rising edge, when ~Stall & CondEx:
//    FlagW[1] -> Flags[3:2] <= ALUFlags[3:2]; FlagW[0] -> Flags[1:0] <= ALUFlags[1:0].
//    The two halves are independent; FlagW=2'b00 leaves Flags unchanged.
//  - Condition-failed instruction: no flag update, all three strobes 0, SquashCnt += 1.
//  - SquashCnt saturates at {CNT_W{1'b1}}; no wrap. Does not count while Stall=1.
//  - Latency: strobes 0-cycle (combinational); new Flags visible to CondEx on the next cycle.
//  - Simultaneous Stall & condition fail: Stall wins (no count, no update).
//  - Reset asserted mid-instruction: Flags and SquashCnt clear immediately; strobes then evaluated
//    against Flags=0000 (e.g. EQ fails, NE passes).
// STRUCTURE
//  - Shared package (cpu_pkg): COND_EQ..COND_AL 4-bit localparams; FLAG_N/Z/C/V bit indices;
//    FLAGW_NZ=2'b10, FLAGW_CV=2'b01.
//  - One sub-module: cond_check (pure combinational Cond x Flags -> CondEx).
//    Flag register, strobe gating and counter live in the top.
// TESTING
//  1. Reset: reset=0 with Cond=0000 -> Flags=0000, SquashCnt=0, CondEx=0; Cond=0001 -> CondEx=1.
//  2. CMP-like: Cond=1110, FlagW=11, ALUFlags=0110 -> next cycle Flags=0110; then Cond=0000,
//     RegW=1 -> RegWrite=1; Cond=0001 -> RegWrite=0, SquashCnt increments by 1.
//  3. Partial write: Flags=1111, FlagW=10, ALUFlags=0000 -> Flags=0011; FlagW=01 -> C,V only.
//  4. Failed condition blocks flags: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1111
//     -> Flags stays 0000, PCSrc=MemWrite=RegWrite=0.
//  5. Stall: Stall=1, Cond=0001, FlagW=11 -> all strobes 0, Flags and SquashCnt frozen.
//  6. Saturation (CNT_W=4): 20 failed cycles -> SquashCnt=4'hF and holds;
//     full 16-entry Cond sweep vs golden table for all 16 Flags values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV bit positions and FlagW masks.
package cpu_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAGW_W = 2;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [FLAGW_W-1:0] FLAGW_NZ = 2'b10;
  localparam logic [FLAGW_W-1:0] FLAGW_CV = 2'b01;

endpackage : cpu_pkg

// File: rtl/cond_check.sv
// Condition evaluator: ARM 4-bit condition field against NZCV flags.
//   cond    : instruction condition field
//   flags   : {N,Z,C,V}
//   cond_ex : 1 when the instruction should execute
module cond_check
  import cpu_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Condition decode; the reserved 1111 encoding executes unconditionally.
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ~(n ^ v);
      COND_LT: cond_ex = n ^ v;
      COND_GT: cond_ex = ~z & ~(n ^ v);
      COND_LE: cond_ex = z | (n ^ v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule : cond_check

// File: rtl/cond_flag_unit.sv
// Conditional-execution unit: holds NZCV, gates decoder strobes on the
// condition result and counts squashed (condition-failed) instructions.
//   clk, reset (async active-low)
//   Stall                     : freeze state, force strobes low
//   Cond, ALUFlags, FlagW     : condition field, ALU flags, flag write enables
//   PCS, RegW, MemW           : decoder strobes
//   PCSrc, RegWrite, MemWrite : committed strobes (combinational)
//   CondEx                    : condition passed (combinational, from Flags)
//   Flags                     : registered {N,Z,C,V}
//   SquashCnt                 : saturating count of condition-failed cycles
module cond_flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic [FLAGW_W-1:0] FlagW,
  input  logic               PCS,
  input  logic               RegW,
  input  logic               MemW,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               CondEx,
  output logic [FLAGS_W-1:0] Flags,
  output logic [CNT_W-1:0]   SquashCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic cond_ex;
  logic commit;
  logic squash;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (Flags),
    .cond_ex (cond_ex)
  );

  assign CondEx   = cond_ex;
  assign commit   = cond_ex & ~Stall;
  assign squash   = ~cond_ex & ~Stall;
  assign PCSrc    = PCS  & commit;
  assign RegWrite = RegW & commit;
  assign MemWrite = MemW & commit;

  // Flag register: NZ and CV halves written independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= '0;
    end else if (commit) begin
      if ((FlagW & FLAGW_NZ) != 2'b00)
        Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if ((FlagW & FLAGW_CV) != 2'b00)
        Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Squash counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SquashCnt <= '0;
    end else if (squash && (SquashCnt != CNT_MAX)) begin
      SquashCnt <= SquashCnt + CNT_W'(1);
    end
  end

endmodule : cond_flag_unit

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             Stall;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCnt;

  int vecs = 0;
  int errs = 0;

  // Reference state
  logic [3:0] m_flags;
  int         m_cnt;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  // Condition rule: pairs of codes share a base predicate, odd codes invert it.
  function automatic logic golden(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic drive(input logic st, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic p, input logic r, input logic m);
    @(negedge clk);
    Stall = st; Cond = c; ALUFlags = af; FlagW = fw; PCS = p; RegW = r; MemW = m;
    #1;
  endtask

  // Advance one clock edge and update the reference model from current inputs.
  task automatic tick();
    logic pass;
    pass = golden(Cond, m_flags);
    @(posedge clk);
    if (!Stall && pass) begin
      if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    if (!Stall && !pass && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    drive(1'b0, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_flags = 4'h0; m_cnt = 0;
    drive(1'b0, 4'b0000, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1);
    vecs++; if (Flags !== 4'h0) begin errs++; $display("FAIL reset_flags got %h want 0", Flags); end
    vecs++; if (SquashCnt !== '0) begin errs++; $display("FAIL reset_cnt got %h want 0", SquashCnt); end
    vecs++; if (CondEx !== 1'b0) begin errs++; $display("FAIL reset_eq got %b want 0", CondEx); end
    Cond = 4'b0001; #1;
    vecs++; if (CondEx !== 1'b1) begin errs++; $display("FAIL reset_ne got %b want 1", CondEx); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_cmp();
    int c0;
    drive(1'b0, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    vecs++; if (Flags !== 4'b0110) begin errs++; $display("FAIL cmp_flags got %b want 0110", Flags); end
    drive(1'b0, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL cmp_eq_regw got %b want 1", RegWrite); end
    tick();
    c0 = m_cnt;
    drive(1'b0, 4'b0001, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL cmp_ne_regw got %b want 0", RegWrite); end
    tick();
    vecs++; if (int'(SquashCnt) !== c0 + 1) begin errs++; $display("FAIL cmp_cnt got %0d want %0d", SquashCnt, c0 + 1); end
  endtask

  task automatic test_partial();
    load_flags(4'b1111);
    drive(1'b0, 4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    vecs++; if (Flags !== 4'b0011) begin errs++; $display("FAIL partial_nz got %b want 0011", Flags); end
    drive(1'b0, 4'b1110, 4'b1110, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    vecs++; if (Flags !== 4'b0010) begin errs++; $display("FAIL partial_cv got %b want 0010", Flags); end
    drive(1'b0, 4'b1110, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    vecs++; if (Flags !== 4'b0010) begin errs++; $display("FAIL partial_none got %b want 0010", Flags); end
  endtask

  task automatic test_fail_blocks();
    load_flags(4'b0000);
    drive(1'b0, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    vecs++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
      errs++; $display("FAIL fail_strobes got %b want 000", {PCSrc, RegWrite, MemWrite}); end
    tick();
    vecs++; if (Flags !== 4'b0000) begin errs++; $display("FAIL fail_flags got %b want 0000", Flags); end
  endtask

  task automatic test_stall();
    logic [3:0] f0;
    logic [CNT_W-1:0] c0;
    load_flags(4'b0000);
    f0 = Flags; c0 = SquashCnt;
    drive(1'b1, 4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    vecs++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
      errs++; $display("FAIL stall_strobes got %b want 000", {PCSrc, RegWrite, MemWrite}); end
    tick();
    vecs++; if (Flags !== 4'b0000) begin errs++; $display("FAIL stall_flags got %b want 0000", Flags); end
    drive(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    vecs++; if (SquashCnt !== c0 || int'(SquashCnt) !== m_cnt) begin
      errs++; $display("FAIL stall_cnt got %0d want %0d", SquashCnt, c0); end
    vecs++; if (Flags !== f0) begin errs++; $display("FAIL stall_fail_flags got %b want %b", Flags, f0); end
  endtask

  task automatic test_async_reset();
    load_flags(4'b0111);
    drive(1'b0, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL areset_pre got %b want 1", RegWrite); end
    reset = 1'b0; m_flags = 4'h0; m_cnt = 0; #1;
    vecs++; if (Flags !== 4'h0 || SquashCnt !== '0) begin
      errs++; $display("FAIL areset_clear got %b/%0d want 0000/0", Flags, SquashCnt); end
    vecs++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL areset_eq got %b want 0", RegWrite); end
    Cond = 4'b0001; #1;
    vecs++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL areset_ne got %b want 1", RegWrite); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_saturation();
    load_flags(4'b0000);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      vecs++; if (int'(SquashCnt) !== m_cnt) begin
        errs++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, SquashCnt, m_cnt); end
    end
    vecs++; if (SquashCnt !== 4'hF) begin errs++; $display("FAIL sat_final got %h want f", SquashCnt); end
  endtask

  task automatic test_sweep();
    logic [3:0] fv, cv;
    logic p, r, m, e;
    for (int f = 0; f < 16; f++) begin
      fv = 4'(f);
      load_flags(fv);
      for (int c = 0; c < 16; c++) begin
        cv = 4'(c);
        p = 1'($urandom); r = 1'($urandom); m = 1'($urandom);
        drive(1'b0, cv, 4'h0, 2'b00, p, r, m);
        e = golden(cv, fv);
        vecs++; if (CondEx !== e || {PCSrc, RegWrite, MemWrite} !== ({p, r, m} & {3{e}})) begin
          errs++; $display("FAIL sweep f=%b c=%b got ce=%b s=%b want ce=%b s=%b",
                           fv, cv, CondEx, {PCSrc, RegWrite, MemWrite}, e, {p, r, m} & {3{e}}); end
      end
    end
  endtask

  task automatic test_random();
    logic st, p, r, m, e;
    logic [3:0] c, af;
    logic [1:0] fw;
    reset = 1'b0; m_flags = 4'h0; m_cnt = 0; #1; reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(3) == 0);
      c = 4'($urandom); af = 4'($urandom); fw = 2'($urandom);
      p = 1'($urandom); r = 1'($urandom); m = 1'($urandom);
      drive(st, c, af, fw, p, r, m);
      e = golden(c, m_flags);
      vecs++; if (CondEx !== e || {PCSrc, RegWrite, MemWrite} !== ({p, r, m} & {3{e && !st}})) begin
        errs++; $display("FAIL rand_comb[%0d] got ce=%b s=%b want ce=%b s=%b", i, CondEx,
                         {PCSrc, RegWrite, MemWrite}, e, {p, r, m} & {3{e && !st}}); end
      tick();
      vecs++; if (Flags !== m_flags || int'(SquashCnt) !== m_cnt) begin
        errs++; $display("FAIL rand_state[%0d] got %b/%0d want %b/%0d", i, Flags, SquashCnt, m_flags, m_cnt); end
    end
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    test_reset();
    test_cmp();
    test_partial();
    test_fail_blocks();
    test_stall();
    test_async_reset();
    test_saturation();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_cond_flag_unit
